// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flip-flop drive sequencer.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int unsigned DC_HOLD     = 0;
  localparam int unsigned DC_REASSERT = 1;

  // Returns {S, R} that moves a flop holding q to target t; never 2'b11.
  function automatic logic [1:0] excite(input logic q, input logic t,
                                        input int unsigned policy);
    logic [1:0] sr;
    sr = 2'b00;
    if ((q != t) || (policy == DC_REASSERT)) begin
      sr = t ? 2'b10 : 2'b01;
    end
    return sr;
  endfunction

endpackage

// File: rtl/sr_target_fifo.sv
// DEPTH x 1 synchronous FIFO with count-based full/empty and wrapping pointers.
module sr_target_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic pop_bit,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_bit = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_bit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sr_drive_sequencer.sv
// Buffers target flop states and drives S/R excitation, verifying Q feedback
// against a shadow copy after each transition.
module sr_drive_sequencer
  import sr_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DC_POLICY = 0,
  parameter int unsigned CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic          s_out,
  output logic          r_out,
  input  logic          q_fb,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] toggle_cnt
);
  state_e        state_q, state_d;
  logic          s_q, s_d, r_q, r_d;
  logic          shadow_q, shadow_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fifo_full, fifo_empty, head_bit;
  logic          pop, load;

  sr_target_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_valid && in_ready),
    .push_bit (in_bit),
    .pop      (pop),
    .pop_bit  (head_bit),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign s_out      = s_q;
  assign r_out      = r_q;
  assign err        = err_q;
  assign toggle_cnt = cnt_q;

  always_comb begin
    state_d  = state_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    shadow_d = shadow_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE:  load = !fifo_empty;
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (q_fb != shadow_q) err_d = 1'b1;
        load    = !fifo_empty;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The comparison above uses the old shadow before a back-to-back reload.
    if (load) begin
      pop          = 1'b1;
      {s_d, r_d}   = excite(shadow_q, head_bit, DC_POLICY);
      shadow_d     = head_bit;
      state_d      = DRIVE;
      if ((head_bit != shadow_q) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      shadow_q <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      r_q      <= r_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Scoreboard bench for sr_drive_sequencer with model SR flops on the feedback.
module tb_sr_drive_sequencer;
  import sr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // Instance 0: hold policy, 8-bit counter. Instance 1: reassert policy, 2-bit counter.
  logic       rst0, iv0, ib0, rdy0, s0, r0, qfb0, busy0, err0, mq0, force0, fval0;
  logic [7:0] cnt0;
  logic       rst1, iv1, ib1, rdy1, s1, r1, qfb1, busy1, err1, mq1;
  logic [1:0] cnt1;

  assign qfb0 = force0 ? fval0 : mq0;
  assign qfb1 = mq1;

  sr_drive_sequencer #(.DEPTH(4), .DC_POLICY(0), .CW(8)) dut0 (
    .clk(clk), .reset(rst0), .in_valid(iv0), .in_bit(ib0), .in_ready(rdy0),
    .s_out(s0), .r_out(r0), .q_fb(qfb0), .busy(busy0), .err(err0), .toggle_cnt(cnt0)
  );

  sr_drive_sequencer #(.DEPTH(4), .DC_POLICY(1), .CW(2)) dut1 (
    .clk(clk), .reset(rst1), .in_valid(iv1), .in_bit(ib1), .in_ready(rdy1),
    .s_out(s1), .r_out(r1), .q_fb(qfb1), .busy(busy1), .err(err1), .toggle_cnt(cnt1)
  );

  always @(posedge clk) begin
    if (rst0) mq0 <= 1'b1; else if (s0) mq0 <= 1'b1; else if (r0) mq0 <= 1'b0;
    if (rst1) mq1 <= 1'b1; else if (s1) mq1 <= 1'b1; else if (r1) mq1 <= 1'b0;
  end

  int checks = 0;
  int errors = 0;
  logic [1:0]  sb0[$], sb1[$];
  int unsigned drv_t0[$];
  bit          overlap = 1'b0;
  bit          saw_full = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitors: each DRIVE cycle presents one S/R pair, compared against the queue.
  always @(negedge clk) begin
    logic [1:0] e;
    if ((s0 && r0) || (s1 && r1)) overlap = 1'b1;
    if (dut0.state_q == DRIVE) begin
      drv_t0.push_back(cyc);
      if (sb0.size() == 0) chk("dut0_unexpected_drive", {s0, r0}, 32'hdead);
      else begin e = sb0.pop_front(); chk("dut0_sr", {s0, r0}, e); end
    end
    if (dut1.state_q == DRIVE) begin
      if (sb1.size() == 0) chk("dut1_unexpected_drive", {s1, r1}, 32'hdead);
      else begin e = sb1.pop_front(); chk("dut1_sr", {s1, r1}, e); end
    end
  end

  task automatic push(input int d, input logic b, input logic [1:0] e);
    logic rdy;
    bit   acc;
    acc = 1'b0;
    @(negedge clk);
    if (d == 0) begin iv0 = 1'b1; ib0 = b; end
    else        begin iv1 = 1'b1; ib1 = b; end
    for (int i = 0; i < 40 && !acc; i++) begin
      if (i > 0) begin @(negedge clk); saw_full = 1'b1; end
      rdy = (d == 0) ? rdy0 : rdy1;
      @(posedge clk);
      acc = rdy;
    end
    if (acc) begin
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end else chk("push_timeout", 0, 1);
    #1;
    if (d == 0) iv0 = 1'b0; else iv1 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (d == 0) ? !busy0 : !busy1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic reset0();
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    sb0.delete();
  endtask

  function automatic logic [1:0] ex_hold(input logic q, input logic t);
    if (q == t) return 2'b00;
    return t ? 2'b10 : 2'b01;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vec;
    logic        sh, t, exp_err;
    int          tog;
    rst0 = 1'b1; rst1 = 1'b1; iv0 = 1'b0; ib0 = 1'b0; iv1 = 1'b0; ib1 = 1'b0;
    force0 = 1'b0; fval0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset_s", s0, 0);       chk("reset_r", r0, 0);
    chk("reset_err", err0, 0);   chk("reset_cnt", cnt0, 0);
    chk("reset_busy", busy0, 0); chk("reset_ready", rdy0, 1);

    // Stream 1,0,0,1 under hold policy.
    drv_t0.delete();
    push(0, 1'b1, 2'b00); push(0, 1'b0, 2'b01); push(0, 1'b0, 2'b00); push(0, 1'b1, 2'b10);
    wait_idle(0);
    chk("hold_toggle_cnt", cnt0, 2);
    chk("hold_err", err0, 0);
    chk("hold_drive_count", drv_t0.size(), 4);
    if (drv_t0.size() == 4)
      for (int i = 0; i < 3; i++) chk("drive_spacing", drv_t0[i+1] - drv_t0[i], 2);

    // Fill/wrap with q_fb stuck high.
    reset0();
    force0 = 1'b1; fval0 = 1'b1; saw_full = 1'b0;
    vec = 16'b0110_1001_1100_0101;
    sh = 1'b1; tog = 0; exp_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      t = vec[i];
      if (t != sh) tog++;
      if (t == 1'b0) exp_err = 1'b1;
      push(0, t, ex_hold(sh, t));
      sh = t;
    end
    wait_idle(0);
    chk("fill_saw_not_ready", saw_full, 1);
    chk("fill_toggle_cnt", cnt0, tog);
    chk("fill_stuck_err", err0, exp_err);
    force0 = 1'b0;

    // Mismatch while shadow is 0, then sticky through good checks.
    reset0();
    force0 = 1'b1; fval0 = 1'b1;
    push(0, 1'b0, 2'b01);
    repeat (3) @(negedge clk);
    chk("err_before_check", err0, 0);
    @(negedge clk);
    chk("err_at_check", err0, 1);
    force0 = 1'b0;
    push(0, 1'b0, 2'b00); push(0, 1'b1, 2'b10);
    wait_idle(0);
    chk("err_sticky", err0, 1);
    chk("err_phase_cnt", cnt0, 2);

    // Reset during DRIVE with three entries queued.
    reset0();
    for (int i = 0; i < 6; i++) push(0, 1'b0, (i == 0) ? 2'b01 : 2'b00);
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk);
    chk("midrst_s", s0, 0);       chk("midrst_r", r0, 0);
    chk("midrst_busy", busy0, 0); chk("midrst_ready", rdy0, 1);
    chk("midrst_cnt", cnt0, 0);
    rst0 = 1'b0;
    sb0.delete();
    push(0, 1'b1, 2'b00);
    wait_idle(0);
    chk("post_rst_cnt", cnt0, 0);

    // Reassert policy and counter saturation on the second instance.
    push(1, 1'b1, 2'b10); push(1, 1'b0, 2'b01); push(1, 1'b0, 2'b01); push(1, 1'b1, 2'b10);
    wait_idle(1);
    chk("reassert_cnt", cnt1, 2);
    for (int i = 0; i < 8; i++) push(1, i[0], i[0] ? 2'b10 : 2'b01);
    wait_idle(1);
    chk("sat_cnt", cnt1, 3);
    chk("reassert_err", err1, 0);

    chk("never_s_and_r", overlap, 0);
    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
